// File: rtl/banco_registros_param.sv
// Parametrised register bank: two registered read ports, one write port,
// write-first bypass, optional PC alias at the top address and a sequenced bulk clear.
module banco_registros_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int PC_MAP    = 1,
    parameter int PC_OFFSET = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              clr_start,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP   = ADDR_W'(DEPTH - 1);
    localparam logic              PC_EN = (PC_MAP != 0);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              wr_ok;
    logic [DATA_W-1:0] pc_val;

    assign busy   = (state_q == CLEAR);
    assign wr_ok  = we && !busy && !(PC_EN && (wa == TOP));
    assign pc_val = pc_in + DATA_W'(PC_OFFSET);
    assign rd1    = rd1_q;
    assign rd2    = rd2_q;

    // Read priority: clear sweep, then PC alias, then bypass, then storage.
    function automatic logic [DATA_W-1:0] read_f(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] entry);
        if (busy)
            return '0;
        else if (PC_EN && (a == TOP))
            return pc_val;
        else if (wr_ok && (wa == a))
            return wd;
        else
            return entry;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        rd1_d   = read_f(ra1, regs_q[ra1]);
        rd2_d   = read_f(ra2, regs_q[ra2]);
        case (state_q)
            IDLE: begin
                if (wr_ok)
                    regs_d[wa] = wd;
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + ADDR_W'(1);
                if (cnt_q == TOP)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            regs_q  <= regs_d;
        end
    end

endmodule
